pb_debounce_events: RTL and testbench
=====================================

Name: pb_debounce_events

Overview:
Upstream conditioning stage for the board push-buttons. It synchronises the raw active-low PUSH_BUTTON_I pins and debounces each one with a 1 kHz sampled shift register. It produces registered level status plus single-cycle press, release and long-press event pulses. Consumers such as counter control, LED toggles and mode selection use the pulses directly and do no edge detection of their own.

Parameters:
NUM_BUTTONS, 4, number of push-buttons handled.
TICK_PERIOD, 50000, CLOCK_50_I cycles per sample tick (1 kHz at 50 MHz).
SHIFT_LEN, 10, debounce shift register length in ticks.
LONG_PRESS_TICKS, 1000, ticks of continuous press before the long-press event (1 s).

Ports:
CLOCK_50_I  input  1  50 MHz clock, the only clock.
RESET_I  input  1  reset: synchronous and active-high.
PUSH_BUTTON_I  input  NUM_BUTTONS  raw button pins, active-low, asynchronous.
status_o  output  NUM_BUTTONS  debounced level, 1 = pressed.
press_pulse_o  output  NUM_BUTTONS  one-cycle pulse on debounced press.
release_pulse_o  output  NUM_BUTTONS  one-cycle pulse on debounced release.
long_pulse_o  output  NUM_BUTTONS  one-cycle pulse after LONG_PRESS_TICKS of held press.
tick_o  output  1  one-cycle sample strobe, exported for reuse by other blocks.

Behaviour:
- Reset: all outputs 0; sync flops 0 (not pressed); shift registers 0; tick counter 0; hold counters 0; FSMs in IDLE. Reset applied mid-press behaves identically: no pulses are emitted while RESET_I=1 or on the cycle it deasserts.
- Synchroniser: 2 flops per button on ~PUSH_BUTTON_I, giving `synced`.
- Tick counter: counts 0..TICK_PERIOD-1, then wraps to 0.
  - tick_o is registered; it is 1 for exactly the cycle after the counter reads TICK_PERIOD-1.
  - First tick_o falls TICK_PERIOD cycles after reset release.
- Shift register: on each cycle with tick_o=1, shift_reg <= {shift_reg[SHIFT_LEN-2:0], synced}.
- Debounced status:
  - status_o <= |shift_reg, registered every cycle.
  - Press is recognised on the first sampled 1.
  - Release is recognised SHIFT_LEN ticks after the last sampled 1.
- Per-button FSM, registered and evaluated every cycle:
  - IDLE: status_o 0->1 -> PRESSED; press_pulse_o=1 next cycle; hold counter <= 0.
  - PRESSED:
    - status_o 1->0 -> IDLE; release_pulse_o=1.
    - Otherwise, on tick_o the hold counter increments.
    - When tick_o and counter == LONG_PRESS_TICKS-1 -> HELD; long_pulse_o=1.
  - HELD: status_o 1->0 -> IDLE; release_pulse_o=1. No further long pulses; the counter holds.
- Latency:
  - press_pulse_o is high 2 cycles after the edge where tick_o shifts in the first 1 (shift -> status -> pulse).
  - The pulse is aligned with the status_o rising edge plus 1 cycle.
- Simultaneous events:
  - Buttons are fully independent; several pulses may assert in the same cycle.
  - release and long cannot coincide for one button. If status falls on the same cycle the long threshold is reached, release wins and long is suppressed.
- Bounce: any 1 sample within the last SHIFT_LEN ticks keeps status_o=1. There are no extra press pulses during bounce.
- Widths:
  - tick counter: $clog2(TICK_PERIOD).
  - hold counter: $clog2(LONG_PRESS_TICKS+1), saturating, never wraps.
- Tick generation is shared by all buttons.

Decomposition:
- Shared package pb_pkg:
  - typedef enum logic [1:0] {PB_IDLE, PB_PRESSED, PB_HELD} pb_state_t.
  - Default constants PB_TICK_PERIOD_50MHZ=50000, PB_SHIFT_LEN=10.
- One natural sub-module: pb_channel, generated NUM_BUTTONS times. It holds the synchroniser, shift register, status, FSM and hold counter for one button, and takes tick as an input.
- The tick counter stays in the top.

Test Plan:
Bench uses TICK_PERIOD=4, SHIFT_LEN=3, LONG_PRESS_TICKS=5.
- Reset check: hold RESET_I=1 for 5 cycles with PUSH_BUTTON_I=4'h0 (all pressed) -> all outputs 0. After release, the first tick_o occurs at cycle 4 and press_pulse_o=4'hF exactly once.
- Clean press/release of button 0 -> one press_pulse_o[0], 2 cycles after the sampling tick. Release -> status_o[0] falls 3 ticks after the last 1 sample, with one release_pulse_o[0] on the next cycle.
- Bounce: toggle PUSH_BUTTON_I[1] every 3 cycles for 30 cycles, then hold pressed -> exactly one press_pulse_o[1]; status_o[1] stays 1 throughout.
- Long press: hold button 2 for 40 cycles -> long_pulse_o[2] exactly once, on the 5th tick after the press pulse. Release -> one release pulse and no second long pulse.
- Release on threshold: release button 3 so status falls on the threshold cycle -> release_pulse_o[3]=1 and long_pulse_o[3]=0.
- Mid-operation reset: assert RESET_I during the HELD state of button 0 -> outputs clear next cycle. After deassert with the button still held, a fresh press_pulse_o[0] occurs.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared types and default constants for the push-button conditioning slice.
package pb_pkg;

  typedef enum logic [1:0] {PB_IDLE, PB_PRESSED, PB_HELD} pb_state_t;

  localparam int PB_TICK_PERIOD_50MHZ = 50000;
  localparam int PB_SHIFT_LEN         = 10;
  localparam int PB_LONG_PRESS_TICKS  = 1000;

endpackage

// File: rtl/pb_channel.sv
// One push-button lane: synchroniser, tick-sampled debounce shift register,
// registered level and a press/hold/release event FSM.
module pb_channel
  import pb_pkg::*;
#(
  parameter int SHIFT_LEN        = PB_SHIFT_LEN,
  parameter int LONG_PRESS_TICKS = PB_LONG_PRESS_TICKS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_n_i,
  input  logic tick_i,
  output logic status_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);

  logic [1:0]           sync_q, sync_d;
  logic [SHIFT_LEN-1:0] shift_q, shift_d;
  logic                 status_q, status_d;
  pb_state_t            state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 long_q, long_d;

  always_comb begin
    sync_d    = {sync_q[0], ~button_n_i};
    shift_d   = shift_q;
    status_d  = |shift_q;
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    if (tick_i) begin
      shift_d = {shift_q[SHIFT_LEN-2:0], sync_q[1]};
    end

    // A falling status is checked first so release always beats the long event.
    case (state_q)
      PB_IDLE: begin
        if (status_q) begin
          state_d = PB_PRESSED;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      PB_PRESSED: begin
        if (!status_q) begin
          state_d   = PB_IDLE;
          release_d = 1'b1;
        end else if (tick_i) begin
          if (hold_q == HOLD_W'(LONG_PRESS_TICKS - 1)) begin
            state_d = PB_HELD;
            long_d  = 1'b1;
          end
          if (hold_q != HOLD_W'(LONG_PRESS_TICKS)) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      PB_HELD: begin
        if (!status_q) begin
          state_d   = PB_IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = PB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      shift_q   <= '0;
      status_q  <= 1'b0;
      state_q   <= PB_IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      shift_q   <= shift_d;
      status_q  <= status_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign status_o  = status_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/pb_debounce_events.sv
// Board push-button conditioning: one shared sample tick feeding NUM_BUTTONS
// independent debounce/event channels.
module pb_debounce_events
  import pb_pkg::*;
#(
  parameter int NUM_BUTTONS      = 4,
  parameter int TICK_PERIOD      = PB_TICK_PERIOD_50MHZ,
  parameter int SHIFT_LEN        = PB_SHIFT_LEN,
  parameter int LONG_PRESS_TICKS = PB_LONG_PRESS_TICKS
) (
  input  logic                   CLOCK_50_I,
  input  logic                   RESET_I,
  input  logic [NUM_BUTTONS-1:0] PUSH_BUTTON_I,
  output logic [NUM_BUTTONS-1:0] status_o,
  output logic [NUM_BUTTONS-1:0] press_pulse_o,
  output logic [NUM_BUTTONS-1:0] release_pulse_o,
  output logic [NUM_BUTTONS-1:0] long_pulse_o,
  output logic                   tick_o
);

  localparam int CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == CNT_W'(TICK_PERIOD - 1));
    cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    pb_channel #(
      .SHIFT_LEN       (SHIFT_LEN),
      .LONG_PRESS_TICKS(LONG_PRESS_TICKS)
    ) u_chan (
      .clk_i     (CLOCK_50_I),
      .rst_i     (RESET_I),
      .button_n_i(PUSH_BUTTON_I[i]),
      .tick_i    (tick_q),
      .status_o  (status_o[i]),
      .press_o   (press_pulse_o[i]),
      .release_o (release_pulse_o[i]),
      .long_o    (long_pulse_o[i])
    );
  end

endmodule

// File: tb/tb_pb_debounce_events.sv
// Bench for pb_debounce_events: directed scenarios plus random button activity,
// compared every cycle against a tick/sample-level behavioural model.
module tb_pb_debounce_events;

  localparam int NB = 4;
  localparam int TP = 4;
  localparam int SL = 3;
  localparam int LP = 5;
  localparam int FAR = 1000;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [NB-1:0] pins = '0;
  logic [NB-1:0] status, press, release_p, long_p;
  logic          tick;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pb_debounce_events #(
    .NUM_BUTTONS     (NB),
    .TICK_PERIOD     (TP),
    .SHIFT_LEN       (SL),
    .LONG_PRESS_TICKS(LP)
  ) dut (
    .CLOCK_50_I     (clk),
    .RESET_I        (reset_i),
    .PUSH_BUTTON_I  (pins),
    .status_o       (status),
    .press_pulse_o  (press),
    .release_pulse_o(release_p),
    .long_pulse_o   (long_p),
    .tick_o         (tick)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: cycles since reset, a 2-deep pin delay, ticks since the last
  // pressed sample per button, and tick counts since each press event.
  int            k;
  logic [NB-1:0] d1, d2;
  int            since_one [NB];
  int            held [NB];
  bit            long_done [NB];
  logic          exp_tick;
  logic [NB-1:0] exp_status, exp_status_prev, exp_press, exp_release, exp_long;
  logic          pend_rst = 1'b1;
  logic [NB-1:0] pend_pins = '0;

  always @(negedge clk) begin : compare
    logic          new_tick;
    logic [NB-1:0] new_status, new_press, new_rel, new_long;
    if (pend_rst) begin
      k = 0;
      d1 = '0;
      d2 = '0;
      exp_tick = 1'b0;
      exp_status = '0;
      exp_status_prev = '0;
      exp_press = '0;
      exp_release = '0;
      exp_long = '0;
      for (int b = 0; b < NB; b++) begin
        since_one[b] = FAR;
        held[b] = 0;
        long_done[b] = 1'b0;
      end
    end else begin
      k++;
      new_tick = (k % TP == 0);
      for (int b = 0; b < NB; b++) begin
        new_status[b] = (since_one[b] < SL);
        new_press[b]  = exp_status[b] & ~exp_status_prev[b];
        new_rel[b]    = ~exp_status[b] & exp_status_prev[b];
        new_long[b]   = 1'b0;
        if (new_press[b]) begin
          held[b] = 0;
          long_done[b] = 1'b0;
        end else if (exp_status[b] && exp_tick) begin
          held[b]++;
          if (held[b] == LP && !long_done[b]) begin
            new_long[b] = 1'b1;
            long_done[b] = 1'b1;
          end
        end
        if (exp_tick) since_one[b] = d2[b] ? 0 : ((since_one[b] < FAR) ? since_one[b] + 1 : FAR);
      end
      d2 = d1;
      d1 = ~pend_pins;
      exp_tick = new_tick;
      exp_status_prev = exp_status;
      exp_status = new_status;
      exp_press = new_press;
      exp_release = new_rel;
      exp_long = new_long;
    end
    pend_rst = reset_i;
    pend_pins = pins;
    checkOutput("tick_o", 32'(tick), 32'(exp_tick));
    checkOutput("status_o", 32'(status), 32'(exp_status));
    checkOutput("press_pulse_o", 32'(press), 32'(exp_press));
    checkOutput("release_pulse_o", 32'(release_p), 32'(exp_release));
    checkOutput("long_pulse_o", 32'(long_p), 32'(exp_long));
  end

  int press_cnt [NB];
  int rel_cnt [NB];
  int long_cnt [NB];

  task automatic clearCounts();
    for (int b = 0; b < NB; b++) begin
      press_cnt[b] = 0;
      rel_cnt[b] = 0;
      long_cnt[b] = 0;
    end
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    #1;
    for (int b = 0; b < NB; b++) begin
      press_cnt[b] += int'(press[b]);
      rel_cnt[b]   += int'(release_p[b]);
      long_cnt[b]  += int'(long_p[b]);
    end
  endtask

  // Inputs change 2 time units after a rising edge and hold for n edges.
  task automatic applyStimulus(input logic r, input logic [NB-1:0] p, input int n);
    @(posedge clk);
    #2;
    reset_i = r;
    pins = p;
    for (int i = 0; i < n; i++) sampleCycle();
  endtask

  // Release reset with pins held and pin the first tick, press and long cycles
  // to hand-computed values (k = edges since reset release).
  task automatic releaseResetHeld(input logic [NB-1:0] p, input logic [NB-1:0] m);
    @(posedge clk);
    #2;
    reset_i = 1'b0;
    pins = p;
    clearCounts();
    for (int i = 0; i <= 30; i++) begin
      sampleCycle();
      if (i == 0) checkOutput("reset_status", 32'(status), 32'(0));
      if (i == 3) checkOutput("first_tick_k3", 32'(tick), 32'(0));
      if (i == 4) checkOutput("first_tick_k4", 32'(tick), 32'(1));
      if (i == 5) checkOutput("status_k5", 32'(status), 32'(0));
      if (i == 6) checkOutput("status_k6", 32'(status), 32'(m));
      if (i == 6) checkOutput("press_k6", 32'(press), 32'(0));
      if (i == 7) checkOutput("press_k7", 32'(press), 32'(m));
      if (i == 8) checkOutput("press_k8", 32'(press), 32'(0));
      if (i == 24) checkOutput("long_k24", 32'(long_p), 32'(0));
      if (i == 25) checkOutput("long_k25", 32'(long_p), 32'(m));
      if (i == 26) checkOutput("long_k26", 32'(long_p), 32'(0));
    end
    for (int b = 0; b < NB; b++) begin
      checkOutput("startup_press_count", 32'(press_cnt[b]), 32'(m[b] ? 1 : 0));
    end
  endtask

  initial begin
    reset_i = 1'b1;
    pins = 4'h0;
    applyStimulus(1'b1, 4'h0, 5);
    checkOutput("reset_press", 32'(press | release_p | long_p), 32'(0));
    checkOutput("reset_tick", 32'(tick), 32'(0));
    releaseResetHeld(4'h0, 4'hF);
    clearCounts();
    applyStimulus(1'b0, 4'hF, 30);
    checkOutput("all_release_count", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'(4));

    clearCounts();
    applyStimulus(1'b0, 4'hE, 20);
    applyStimulus(1'b0, 4'hF, 25);
    checkOutput("clean_press0", 32'(press_cnt[0]), 32'(1));
    checkOutput("clean_release0", 32'(rel_cnt[0]), 32'(1));

    clearCounts();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, (i % 2 == 0) ? 4'hD : 4'hF, 3);
    applyStimulus(1'b0, 4'hD, 30);
    checkOutput("bounce_press1", 32'(press_cnt[1]), 32'(1));
    checkOutput("bounce_release1", 32'(rel_cnt[1]), 32'(0));
    applyStimulus(1'b0, 4'hF, 25);

    clearCounts();
    applyStimulus(1'b0, 4'hB, 40);
    applyStimulus(1'b0, 4'hF, 30);
    checkOutput("long2_count", 32'(long_cnt[2]), 32'(1));
    checkOutput("long2_release", 32'(rel_cnt[2]), 32'(1));

    for (int d = 8; d <= 22; d++) begin
      clearCounts();
      applyStimulus(1'b0, 4'h7, d);
      applyStimulus(1'b0, 4'hF, 30);
      checkOutput("thr3_press", 32'(press_cnt[3]), 32'(1));
      checkOutput("thr3_release", 32'(rel_cnt[3]), 32'(1));
    end

    applyStimulus(1'b0, 4'hE, 40);
    applyStimulus(1'b1, 4'hE, 3);
    checkOutput("midreset_status", 32'(status), 32'(0));
    checkOutput("midreset_events", 32'(press | release_p | long_p), 32'(0));
    releaseResetHeld(4'hE, 4'h1);
    applyStimulus(1'b0, 4'hF, 30);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
                    NB'($urandom_range(0, 15)), $urandom_range(1, 12));
    end
    applyStimulus(1'b0, 4'hF, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
